// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU request sequencer.
//   OP_*     ALU opcodes as seen on alu_op / req_op
//   state_e  sequencer FSM states
//   WIDTH    default operand width (must match the ALU)
package alu_pkg;
  localparam int WIDTH = 3;

  localparam logic [1:0] OP_SUM = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational 2-way round-robin grant.
//   req_valid  in  2  request valid per requester
//   rr_ptr     in  1  preferred requester when both are valid
//   grant      out 2  one-hot grant, zero when nobody requests
module rr_arb2 (
  input  logic [1:0] req_valid,
  input  logic       rr_ptr,
  output logic [1:0] grant
);
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // Contention only: the pointer never blocks a lone requester.
      2'b11:   grant = rr_ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end
endmodule

// File: rtl/alu_req_sequencer.sv
// alu_req_sequencer: two-requester front end for the shared combinational ALU.
// Accepts one op at a time (round-robin between requesters), registers the
// operands into the ALU, lets them settle one cycle, captures the result and
// returns it with the requester id. Keeps a saturating count of ALU errors.
//   clk, rst_n                      clock / async active-low reset
//   req_valid/req_ready/req_in1/req_in2/req_op   packed per-requester requests
//   alu_in1/alu_in2/alu_op          registered operands to the ALU
//   alu_dec_bin/alu_unis_bin/alu_zero/alu_error  ALU result
//   rsp_valid/rsp_ready/rsp_id/rsp_dec/rsp_unis/rsp_zero/rsp_error  response
//   busy                            FSM not idle
//   err_cnt/err_clr                 saturating error count and its clear
module alu_req_sequencer #(
  parameter int WIDTH     = 3,
  parameter int ERR_CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [2*WIDTH-1:0]   req_in1,
  input  logic [2*WIDTH-1:0]   req_in2,
  input  logic [3:0]           req_op,
  output logic [WIDTH-1:0]     alu_in1,
  output logic [WIDTH-1:0]     alu_in2,
  output logic [1:0]           alu_op,
  input  logic [3:0]           alu_dec_bin,
  input  logic [3:0]           alu_unis_bin,
  input  logic                 alu_zero,
  input  logic                 alu_error,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [3:0]           rsp_dec,
  output logic [3:0]           rsp_unis,
  output logic                 rsp_zero,
  output logic                 rsp_error,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_cnt,
  input  logic                 err_clr
);
  import alu_pkg::*;

  state_e     r_state, w_next;
  logic       r_rr_ptr;
  logic       r_id;       // id of the op in flight; copied to rsp_id at capture
  logic [1:0] w_grant;
  logic       w_gid;
  logic       w_acc;
  logic       w_exec;

  rr_arb2 u_arb (
    .req_valid (req_valid),
    .rr_ptr    (r_rr_ptr),
    .grant     (w_grant)
  );

  assign w_gid  = w_grant[1];
  assign w_acc  = (r_state == S_IDLE) && (w_grant != 2'b00);
  assign w_exec = (r_state == S_EXEC);
  assign busy   = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 2'b00;
    case (r_state)
      S_IDLE: begin
        req_ready = w_grant;
        if (w_acc) w_next = S_EXEC;
      end
      S_EXEC:  w_next = S_RESP;
      // rsp_valid is always high in RESP, so rsp_ready alone completes it.
      S_RESP:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr  <= 1'b0;
      r_id      <= 1'b0;
      alu_in1   <= '0;
      alu_in2   <= '0;
      alu_op    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_dec   <= '0;
      rsp_unis  <= '0;
      rsp_zero  <= 1'b0;
      rsp_error <= 1'b0;
      err_cnt   <= '0;
    end else begin
      // Operands stay put after the op so the ALU inputs do not toggle in IDLE.
      if (w_acc) begin
        alu_in1  <= req_in1[w_gid*WIDTH +: WIDTH];
        alu_in2  <= req_in2[w_gid*WIDTH +: WIDTH];
        alu_op   <= req_op[w_gid*2 +: 2];
        r_id     <= w_gid;
        r_rr_ptr <= ~w_gid;
      end

      if (w_exec) begin
        rsp_valid <= 1'b1;
        rsp_id    <= r_id;
        rsp_dec   <= alu_dec_bin;
        rsp_unis  <= alu_unis_bin;
        rsp_zero  <= alu_zero;
        rsp_error <= alu_error;
      end else if ((r_state == S_RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end

      if (err_clr)
        err_cnt <= '0;
      else if (w_exec && alu_error && (err_cnt != '1))
        err_cnt <= err_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_alu_req_sequencer.sv
module tb_alu_req_sequencer;
  import alu_pkg::*;

  localparam int W  = 3;
  localparam int EW = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [1:0]     req_valid = 2'b00;
  logic [1:0]     req_ready;
  logic [2*W-1:0] req_in1 = '0;
  logic [2*W-1:0] req_in2 = '0;
  logic [3:0]     req_op = '0;
  logic [W-1:0]   alu_in1, alu_in2;
  logic [1:0]     alu_op;
  logic [3:0]     alu_dec_bin, alu_unis_bin;
  logic           alu_zero, alu_error;
  logic           rsp_valid;
  logic           rsp_ready = 1'b1;
  logic           rsp_id;
  logic [3:0]     rsp_dec, rsp_unis;
  logic           rsp_zero, rsp_error, busy;
  logic [EW-1:0]  err_cnt;
  logic           err_clr = 1'b0;

  always #5 clk = ~clk;

  alu_req_sequencer #(.WIDTH(W), .ERR_CNT_W(EW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2), .req_op(req_op),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
    .alu_dec_bin(alu_dec_bin), .alu_unis_bin(alu_unis_bin),
    .alu_zero(alu_zero), .alu_error(alu_error),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_dec(rsp_dec), .rsp_unis(rsp_unis), .rsp_zero(rsp_zero),
    .rsp_error(rsp_error), .busy(busy), .err_cnt(err_cnt), .err_clr(err_clr)
  );

  // Stand-in for the shared ALU: BCD result, error on divide-by-zero or
  // negative difference.
  int   alu_r;
  logic alu_e;
  always_comb begin
    alu_r = 0;
    alu_e = 1'b0;
    case (alu_op)
      OP_SUM:  alu_r = int'(alu_in1) + int'(alu_in2);
      OP_SUB:  if (alu_in1 < alu_in2) alu_e = 1'b1; else alu_r = int'(alu_in1) - int'(alu_in2);
      OP_MUL:  alu_r = int'(alu_in1) * int'(alu_in2);
      default: if (alu_in2 == '0) alu_e = 1'b1; else alu_r = int'(alu_in1) / int'(alu_in2);
    endcase
    alu_dec_bin  = 4'(alu_r / 10);
    alu_unis_bin = 4'(alu_r % 10);
    alu_zero     = !alu_e && (alu_r == 0);
    alu_error    = alu_e;
  end

  typedef struct packed {
    logic       id;
    logic [3:0] dec;
    logic [3:0] unis;
    logic       zero;
    logic       err;
  } rsp_t;

  rsp_t sb[$];
  logic acc_log[$];
  rsp_t m_exp;
  int   n_chk = 0;
  int   n_pass = 0;

  function automatic rsp_t mk(input logic id, input int dec, input int unis,
                              input logic zero, input logic err);
    rsp_t r;
    r.id = id; r.dec = 4'(dec); r.unis = 4'(unis); r.zero = zero; r.err = err;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor: every response handshake pops the next expected response.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        m_exp = sb.pop_front();
        chk("rsp_id",    32'(rsp_id),    32'(m_exp.id));
        chk("rsp_dec",   32'(rsp_dec),   32'(m_exp.dec));
        chk("rsp_unis",  32'(rsp_unis),  32'(m_exp.unis));
        chk("rsp_zero",  32'(rsp_zero),  32'(m_exp.zero));
        chk("rsp_error", 32'(rsp_error), 32'(m_exp.err));
      end
    end
  end

  // Drives one request, waits for its grant, drops valid after the accept
  // edge and returns 1ns after that edge (FSM now in EXEC).
  task automatic issue(input int id, input int a, input int b, input logic [1:0] op,
                       input logic push, input rsp_t exp);
    int  t;
    logic ok;
    t  = 0;
    ok = 1'b0;
    req_in1[id*W +: W] = W'(a);
    req_in2[id*W +: W] = W'(b);
    req_op[id*2 +: 2]  = op;
    req_valid[id]      = 1'b1;
    while (!ok && t < 60) begin
      @(negedge clk);
      if (req_ready[id]) ok = 1'b1;
      t++;
    end
    if (!ok) chk("grant_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    if (ok) begin
      if (push) sb.push_back(exp);
      acc_log.push_back(id[0]);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (busy) chk("idle_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset values, before any clock edge
    #2;
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_alu_in1",   32'(alu_in1),   32'd0);
    chk("rst_alu_op",    32'(alu_op),    32'd0);
    chk("rst_err_cnt",   32'(err_cnt),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: lone SUM; rsp_valid low after the accept edge, high after the next
    issue(0, 3, 2, OP_SUM, 1'b1, mk(0, 0, 5, 0, 0));
    chk("t1_valid_in_exec", 32'(rsp_valid), 32'd0);
    chk("t1_busy",          32'(busy),      32'd1);
    @(posedge clk); #1;
    chk("t1_valid_after_capture", 32'(rsp_valid), 32'd1);
    wait_idle();

    // 2: both valid right after reset, requester 0 wins first
    do_reset();
    acc_log.delete();
    fork
      issue(0, 5, 3, OP_SUB, 1'b1, mk(0, 0, 2, 0, 0));
      issue(1, 4, 2, OP_MUL, 1'b1, mk(1, 0, 8, 0, 0));
    join
    wait_idle();
    chk("t2_first_grant", 32'(acc_log[0]), 32'd0);

    // 3: divide by zero, saturation, clear beating an increment
    issue(1, 6, 0, OP_DIV, 1'b1, mk(1, 0, 0, 0, 1));
    wait_idle();
    chk("t3_err_cnt_1", 32'(err_cnt), 32'd1);
    for (int i = 2; i <= 16; i++) begin
      issue(1, 6, 0, OP_DIV, 1'b1, mk(1, 0, 0, 0, 1));
      wait_idle();
      chk($sformatf("t3_err_cnt_%0d", i), 32'(err_cnt), (i > 15) ? 32'd15 : 32'(i));
    end
    issue(1, 6, 0, OP_DIV, 1'b1, mk(1, 0, 0, 0, 1));
    err_clr = 1'b1;   // lands on the EXEC capture edge
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("t3_clr_wins", 32'(err_cnt), 32'd0);
    wait_idle();

    // 4: response back-pressure, 5-5 = 0
    rsp_ready = 1'b0;
    issue(0, 5, 5, OP_SUB, 1'b1, mk(0, 0, 0, 1, 0));
    @(posedge clk); #1;
    req_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", 32'(rsp_valid), 32'd1);
      chk("t4_hold_zero",  32'(rsp_zero),  32'd1);
      chk("t4_hold_unis",  32'(rsp_unis),  32'd0);
      chk("t4_req_ready",  32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("t4_idle_after_release", 32'(busy),      32'd0);
    chk("t4_valid_dropped",      32'(rsp_valid), 32'd0);
    chk("t4_rsp_kept",           32'(rsp_zero),  32'd1);

    // 5: reset during EXEC aborts the op (requester 0 accepted -> pointer 1)
    issue(0, 6, 5, OP_MUL, 1'b0, mk(0, 0, 0, 0, 0));
    chk("t5_in_exec", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_busy",     32'(busy),      32'd0);
    chk("t5_alu_in1",  32'(alu_in1),   32'd0);
    chk("t5_alu_in2",  32'(alu_in2),   32'd0);
    chk("t5_alu_op",   32'(alu_op),    32'd0);
    chk("t5_rsp_zero", 32'(rsp_zero),  32'd0);
    chk("t5_rsp_valid",32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_no_rsp", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    acc_log.delete();
    fork
      issue(0, 1, 2, OP_SUM, 1'b1, mk(0, 0, 3, 0, 0));
      issue(1, 3, 3, OP_MUL, 1'b1, mk(1, 0, 9, 0, 0));
    join
    wait_idle();
    chk("t5_ptr_reset", 32'(acc_log[0]), 32'd0);

    // 6: both requesters continuously valid for 6 ops
    acc_log.delete();
    fork
      begin
        issue(0, 1, 1, OP_SUM, 1'b1, mk(0, 0, 2, 0, 0));
        issue(0, 2, 2, OP_SUM, 1'b1, mk(0, 0, 4, 0, 0));
        issue(0, 3, 3, OP_SUM, 1'b1, mk(0, 0, 6, 0, 0));
      end
      begin
        issue(1, 7, 7, OP_MUL, 1'b1, mk(1, 4, 9, 0, 0));
        issue(1, 2, 3, OP_MUL, 1'b1, mk(1, 0, 6, 0, 0));
        issue(1, 7, 1, OP_SUB, 1'b1, mk(1, 0, 6, 0, 0));
      end
    join
    wait_idle();
    chk("t6_n_grants", 32'(acc_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < acc_log.size(); i++)
      chk($sformatf("t6_grant_%0d", i), 32'(acc_log[i]), 32'(i % 2));

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
